// File: rtl/dac_pkg.sv
// Shared frame constants, sequencer state encoding and frame builder for the serial DAC controller.
// Frame layout: 8 lead zeros, 4-bit command, 4-bit address, 16-bit data, MSB first.
// No flow control lives here; pure types and helpers.
package dac_pkg;

  localparam int FRAME_W = 32;
  localparam int LEAD_W = 8;
  localparam logic [3:0] CMD_WR_UPD = 4'h3;

  typedef enum logic [1:0] {
    IDLE,
    LATCH,
    SHIFT,
    GAP
  } state_t;

  function automatic logic [FRAME_W-1:0] build_frame(input logic [3:0] cmd,
                                                     input logic [3:0] addr,
                                                     input logic [15:0] data);
    return {{LEAD_W{1'b0}}, cmd, addr, data};
  endfunction

endpackage

// File: rtl/dac_shift.sv
// One-frame serializer: ld low for 64*CLK_DIV cycles, sck rises CLK_DIV after ld falls, sdi moves on sck fall.
// Latency: ld/sdi change on the edge that samples load; done is high in the cycle ending the last sck fall.
// No backpressure: a load while a frame is in flight restarts the frame.
module dac_shift
  import dac_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [FRAME_W-1:0] word,
  output logic               sck,
  output logic               sdi,
  output logic               ld,
  output logic               done
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] DIV_MAX = CW'(CLK_DIV - 1);
  localparam logic [5:0] TGL_LAST = 6'(2 * FRAME_W - 1);

  logic [CW-1:0]      div_cnt;
  logic [5:0]         tgl_cnt;
  logic [FRAME_W-1:0] shreg;
  logic               tgl;

  assign tgl  = !ld && (div_cnt == DIV_MAX);
  // The 64th toggle is the 32nd falling edge, which also closes the frame.
  assign done = tgl && sck && (tgl_cnt == TGL_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sck     <= 1'b0;
      sdi     <= 1'b0;
      ld      <= 1'b1;
      div_cnt <= '0;
      tgl_cnt <= '0;
      shreg   <= '0;
    end else if (load) begin
      ld      <= 1'b0;
      sck     <= 1'b0;
      sdi     <= word[FRAME_W-1];
      shreg   <= {word[FRAME_W-2:0], 1'b0};
      div_cnt <= '0;
      tgl_cnt <= '0;
    end else if (!ld) begin
      if (tgl) begin
        div_cnt <= '0;
        tgl_cnt <= tgl_cnt + 6'd1;
        sck     <= ~sck;
        if (done) begin
          ld  <= 1'b1;
          sdi <= 1'b0;
        end else if (sck) begin
          sdi   <= shreg[FRAME_W-1];
          shreg <= {shreg[FRAME_W-2:0], 1'b0};
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/dac_multi.sv
// NUM_CH-channel LTC2624-style serial DAC controller; DAC_SIGNED_IN_EN selects two's-complement sample input.
// Latency: strobe sampled at edge t -> LATCH/next in cycle t+1 -> ld falls at t+1; a set spans 1+NUM_CH*65*CLK_DIV cycles.
// Backpressure: one strobe is held pending while busy; a further strobe is dropped and flagged with overrun.
module dac_multi
  import dac_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int SAMPLE_W = 16,
  parameter int CLK_DIV  = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CH*SAMPLE_W-1:0]   sample,
  input  logic                         strobe,
  output logic                         next,
  output logic                         busy,
  output logic                         overrun,
  output logic                         sck,
  output logic                         sdi,
  output logic                         ld
);

  localparam int GW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [GW-1:0] GAP_MAX = GW'(CLK_DIV - 1);
  localparam logic [3:0] LAST_CH = 4'(NUM_CH - 1);

  state_t                       state, state_nxt;
  logic [3:0]                   ch;
  logic                         pending;
  logic [GW-1:0]                gap_cnt;
  logic [NUM_CH*SAMPLE_W-1:0]   sample_cvt;
  logic [NUM_CH*SAMPLE_W-1:0]   samp_q;
  logic [SAMPLE_W-1:0]          sel_samp;
  logic                         load;
  logic [FRAME_W-1:0]           word;
  logic                         done;
  logic                         gap_end;
  logic                         last_ch;
  logic                         take_pend;
  logic                         strobe_busy;

  function automatic logic [15:0] justify(input logic [SAMPLE_W-1:0] s);
    return 16'(s) << (16 - SAMPLE_W);
  endfunction

`ifdef DAC_SIGNED_IN_EN
  // Flipping the sign bit turns two's complement into offset binary.
  always_comb begin
    sample_cvt = sample;
    for (int c = 0; c < NUM_CH; c++) begin
      sample_cvt[c*SAMPLE_W+SAMPLE_W-1] = ~sample[c*SAMPLE_W+SAMPLE_W-1];
    end
  end
`else
  assign sample_cvt = sample;
`endif

  assign gap_end     = (state == GAP) && (gap_cnt == GAP_MAX);
  assign last_ch     = (ch == LAST_CH);
  assign take_pend   = gap_end && last_ch && pending;
  assign strobe_busy = strobe && (state != IDLE);

  assign next = (state == LATCH);
  assign busy = (state != IDLE) || pending;

  always_comb begin
    sel_samp = samp_q[SAMPLE_W-1:0];
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch + 4'd1 == 4'(c)) sel_samp = samp_q[c*SAMPLE_W +: SAMPLE_W];
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    word      = '0;
    case (state)
      IDLE: begin
        if (strobe) state_nxt = LATCH;
      end
      LATCH: begin
        // Channel 0 comes straight from the inputs being latched this cycle.
        load      = 1'b1;
        word      = build_frame(CMD_WR_UPD, 4'd0, justify(sample_cvt[SAMPLE_W-1:0]));
        state_nxt = SHIFT;
      end
      SHIFT: begin
        if (done) state_nxt = GAP;
      end
      GAP: begin
        if (gap_end) begin
          if (!last_ch) begin
            load      = 1'b1;
            word      = build_frame(CMD_WR_UPD, ch + 4'd1, justify(sel_samp));
            state_nxt = SHIFT;
          end else if (pending) begin
            state_nxt = LATCH;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      ch      <= 4'd0;
      gap_cnt <= '0;
      pending <= 1'b0;
      overrun <= 1'b0;
      samp_q  <= '0;
    end else begin
      state   <= state_nxt;
      gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;
      if (state == LATCH) begin
        ch     <= 4'd0;
        samp_q <= sample_cvt;
      end else if (gap_end && !last_ch) begin
        ch <= ch + 4'd1;
      end
      // A strobe arriving as the pending set is consumed re-arms pending rather than overrunning.
      if (strobe_busy) pending <= 1'b1;
      else if (take_pend) pending <= 1'b0;
      overrun <= strobe_busy && pending && !take_pend;
    end
  end

  dac_shift #(
    .CLK_DIV(CLK_DIV)
  ) u_shift (
    .clk  (clk),
    .reset(reset),
    .load (load),
    .word (word),
    .sck  (sck),
    .sdi  (sdi),
    .ld   (ld),
    .done (done)
  );

endmodule

// File: tb/tb_dac_multi.sv
// Bench for dac_multi: a 2ch/16b/div2 instance and a 1ch/12b/div1 instance, random samples vs a frame-level model.
module tb_dac_multi;

  localparam int NC  = 2;
  localparam int SW  = 16;
  localparam int CD  = 2;
  localparam int SW1 = 12;
  localparam int CD1 = 1;
  localparam int SET_LEN = 1 + NC * 65 * CD;
`ifdef DAC_SIGNED_IN_EN
  localparam bit SIGNED_IN = 1'b1;
`else
  localparam bit SIGNED_IN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [NC*SW-1:0] sample = '0;
  logic strobe = 1'b0;
  logic next, busy, overrun, sck, sdi, ld;
  logic [SW1-1:0] sample1 = '0;
  logic strobe1 = 1'b0;
  logic next1, busy1, overrun1, sck1, sdi1, ld1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dac_multi #(.NUM_CH(NC), .SAMPLE_W(SW), .CLK_DIV(CD)) dut (
    .clk(clk), .reset(reset), .sample(sample), .strobe(strobe), .next(next), .busy(busy),
    .overrun(overrun), .sck(sck), .sdi(sdi), .ld(ld)
  );

  dac_multi #(.NUM_CH(1), .SAMPLE_W(SW1), .CLK_DIV(CD1)) dut1 (
    .clk(clk), .reset(reset), .sample(sample1), .strobe(strobe1), .next(next1), .busy(busy1),
    .overrun(overrun1), .sck(sck1), .sdi(sdi1), .ld(ld1)
  );

  // Expected LTC2624 word: 8'h00, cmd 3, address, sample left-justified into 16 bits.
  function automatic logic [31:0] exp_frame(input int chn, input int s, input int w);
    int d;
    d = s;
    if (SIGNED_IN) d = d ^ (1 << (w - 1));
    d = (d << (16 - w)) & 32'h0000_FFFF;
    return 32'h0030_0000 + (chn << 16) + d;
  endfunction

  // Bus monitor for the main instance, sampled on the falling clock edge.
  int ncyc = 0;
  logic [31:0] bits = '0;
  int nbits = 0;
  logic ld_p = 1'b1, sck_p = 1'b0, busy_p = 1'b0;
  logic [31:0] got_q[$];
  int nb_q[$], fall_q[$], rise_q[$], next_q[$], ovr_q[$];
  int busy_rise = 0, busy_fall = 0;

  always @(negedge clk) begin
    ncyc++;
    if (!ld && ld_p) begin
      fall_q.push_back(ncyc);
      bits = '0;
      nbits = 0;
    end
    if (!ld && sck && !sck_p) begin
      bits = {bits[30:0], sdi};
      nbits++;
    end
    if (ld && !ld_p) begin
      rise_q.push_back(ncyc);
      got_q.push_back(bits);
      nb_q.push_back(nbits);
    end
    if (next) next_q.push_back(ncyc);
    if (overrun) ovr_q.push_back(ncyc);
    if (busy && !busy_p) busy_rise = ncyc;
    if (!busy && busy_p) busy_fall = ncyc;
    ld_p = ld;
    sck_p = sck;
    busy_p = busy;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    got_q.delete(); nb_q.delete(); fall_q.delete(); rise_q.delete();
    next_q.delete(); ovr_q.delete();
  endtask

  task automatic pulse_strobe(input int n);
    strobe = 1'b1;
    repeat (n) tick();
    strobe = 1'b0;
  endtask

  task automatic wait_idle(input int max, input string name);
    int i;
    for (i = 0; i < max && busy; i++) tick();
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL %s idle timeout: busy=%0b after %0d cycles, required 0", name, busy, max);
    end
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) tick();
    checks++;
    if ({sck, sdi, ld, next, busy, overrun} !== 6'b001000) begin
      errors++;
      $display("FAIL reset_outputs: got %b, required 001000", {sck, sdi, ld, next, busy, overrun});
    end
    checks++;
    if ({sck1, sdi1, ld1, next1, busy1, overrun1} !== 6'b001000) begin
      errors++;
      $display("FAIL reset_outputs1: got %b, required 001000", {sck1, sdi1, ld1, next1, busy1, overrun1});
    end
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if ({sck, sdi, ld, next, busy, overrun} !== 6'b001000) begin
      errors++;
      $display("FAIL post_reset_idle: got %b, required 001000", {sck, sdi, ld, next, busy, overrun});
    end
  endtask

  task automatic test_single(input logic [31:0] s);
    logic [31:0] e;
    sample = s;
    clear_mon();
    pulse_strobe(1);
    wait_idle(600, "single");
    checks++;
    if (next_q.size() != 1 || got_q.size() != NC || ovr_q.size() != 0) begin
      errors++;
      $display("FAIL single_counts: next=%0d frames=%0d ovr=%0d, required 1 %0d 0",
               next_q.size(), got_q.size(), ovr_q.size(), NC);
    end
    checks++;
    if (busy_fall - busy_rise != SET_LEN) begin
      errors++;
      $display("FAIL single_busy_len: got %0d, required %0d", busy_fall - busy_rise, SET_LEN);
    end
    checks++;
    if (fall_q.size() > 0 && next_q.size() > 0 && fall_q[0] - next_q[0] != 1) begin
      errors++;
      $display("FAIL single_ld_latency: got %0d, required 1", fall_q[0] - next_q[0]);
    end
    for (int i = 0; i < NC && i < got_q.size(); i++) begin
      e = exp_frame(i, int'(s[i*SW +: SW]), SW);
      checks++;
      if (got_q[i] !== e || nb_q[i] != 32) begin
        errors++;
        $display("FAIL single_frame%0d: got %h (%0d bits), required %h (32 bits)", i, got_q[i], nb_q[i], e);
      end
      checks++;
      if (rise_q[i] - fall_q[i] != 64 * CD) begin
        errors++;
        $display("FAIL single_ld_low%0d: got %0d, required %0d", i, rise_q[i] - fall_q[i], 64 * CD);
      end
      if (i > 0) begin
        checks++;
        if (fall_q[i] - rise_q[i-1] != CD) begin
          errors++;
          $display("FAIL single_gap%0d: got %0d, required %0d", i, fall_q[i] - rise_q[i-1], CD);
        end
      end
    end
  endtask

  // Two sets, the second taken from the pending slot; s1 feeds set 1, s2 feeds set 2.
  task automatic check_two_sets(input string name, input logic [31:0] s1, input logic [31:0] s2,
                                input int n_ovr);
    logic [31:0] sv, e;
    checks++;
    if (next_q.size() != 2 || got_q.size() != 2 * NC || ovr_q.size() != n_ovr) begin
      errors++;
      $display("FAIL %s_counts: next=%0d frames=%0d ovr=%0d, required 2 %0d %0d",
               name, next_q.size(), got_q.size(), ovr_q.size(), 2 * NC, n_ovr);
    end
    checks++;
    if (busy_fall - busy_rise != 2 * SET_LEN) begin
      errors++;
      $display("FAIL %s_busy_len: got %0d, required %0d", name, busy_fall - busy_rise, 2 * SET_LEN);
    end
    checks++;
    if (next_q.size() == 2 && rise_q.size() >= NC && next_q[1] - rise_q[NC-1] != CD) begin
      errors++;
      $display("FAIL %s_latch_gap: got %0d, required %0d", name, next_q[1] - rise_q[NC-1], CD);
    end
    for (int i = 0; i < 2 * NC && i < got_q.size(); i++) begin
      sv = (i < NC) ? s1 : s2;
      e = exp_frame(i % NC, int'(sv[(i % NC)*SW +: SW]), SW);
      checks++;
      if (got_q[i] !== e) begin
        errors++;
        $display("FAIL %s_frame%0d: got %h, required %h", name, i, got_q[i], e);
      end
    end
  endtask

  task automatic test_pending();
    logic [31:0] s1, s2;
    s1 = $urandom;
    s2 = $urandom;
    sample = s1;
    clear_mon();
    pulse_strobe(1);
    repeat (40) tick();
    sample = s2;
    pulse_strobe(1);
    wait_idle(1200, "pending");
    check_two_sets("pending", s1, s2, 0);
  endtask

  task automatic test_latch_strobe();
    logic [31:0] s1;
    s1 = $urandom;
    sample = s1;
    clear_mon();
    pulse_strobe(2);
    wait_idle(1200, "latch_strobe");
    check_two_sets("latch_strobe", s1, s1, 0);
  endtask

  task automatic test_overrun();
    logic [31:0] s1, s2;
    int t3;
    s1 = $urandom;
    s2 = $urandom;
    sample = s1;
    clear_mon();
    pulse_strobe(1);
    repeat (10) tick();
    sample = s2;
    pulse_strobe(1);
    repeat (30) tick();
    pulse_strobe(1);
    t3 = ncyc;
    wait_idle(1200, "overrun");
    check_two_sets("overrun", s1, s2, 1);
    checks++;
    if (ovr_q.size() > 0 && ovr_q[0] != t3) begin
      errors++;
      $display("FAIL overrun_time: got cycle %0d, required %0d", ovr_q[0], t3);
    end
  endtask

  task automatic test_narrow(input logic [SW1-1:0] v);
    logic [31:0] w, e;
    int nb, low, bsy;
    logic sp;
    sample1 = v;
    strobe1 = 1'b1;
    tick();
    strobe1 = 1'b0;
    checks++;
    if (next1 !== 1'b1) begin
      errors++;
      $display("FAIL narrow_next: got %b, required 1", next1);
    end
    w = '0; nb = 0; low = 0; bsy = 0; sp = 1'b0;
    for (int i = 0; i < 300 && busy1; i++) begin
      bsy++;
      if (!ld1) low++;
      if (!ld1 && sck1 && !sp) begin
        w = {w[30:0], sdi1};
        nb++;
      end
      sp = sck1;
      tick();
    end
    e = exp_frame(0, int'(v), SW1);
    checks++;
    if (w !== e || nb != 32) begin
      errors++;
      $display("FAIL narrow_frame: got %h (%0d bits), required %h (32 bits)", w, nb, e);
    end
    checks++;
    if (low != 64 * CD1 || bsy != 1 + 65 * CD1) begin
      errors++;
      $display("FAIL narrow_timing: ld_low=%0d busy=%0d, required %0d %0d", low, bsy, 64 * CD1, 1 + 65 * CD1);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] s;
    int i;
    s = $urandom;
    sample = s;
    clear_mon();
    pulse_strobe(1);
    for (i = 0; i < 400 && fall_q.size() < 2; i++) tick();
    checks++;
    if (fall_q.size() < 2) begin
      errors++;
      $display("FAIL reset_mid_wait: channel 1 frame not started, falls=%0d required 2", fall_q.size());
    end
    repeat (20) tick();
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({ld, sck, busy, next, overrun} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_mid_outputs: ld,sck,busy,next,ovr=%b required 10000", {ld, sck, busy, next, overrun});
    end
    repeat (3) tick();
    reset = 1'b1;
    repeat (3) tick();
    s = $urandom;
    sample = s;
    clear_mon();
    pulse_strobe(1);
    wait_idle(600, "reset_mid");
    checks++;
    if (got_q.size() != NC || got_q[0] !== exp_frame(0, int'(s[SW-1:0]), SW) || nb_q[0] != 32) begin
      errors++;
      $display("FAIL reset_mid_frame0: frames=%0d got %h, required %0d frames %h",
               got_q.size(), got_q.size() > 0 ? got_q[0] : 32'h0, NC, exp_frame(0, int'(s[SW-1:0]), SW));
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single({16'hAA55, 16'h0FF0});
    test_single({16'h8000, 16'h0000});
    for (int k = 0; k < 4; k++) test_single($urandom);
    test_pending();
    test_latch_strobe();
    test_overrun();
    test_narrow(12'hABC);
    for (int k = 0; k < 3; k++) test_narrow(SW1'($urandom));
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dac_multi.md
Name: dac_multi

Overview:
- Parametrised successor to the two-channel serial DAC controller.
- Drives an SPI-style serial DAC (LTC2624 command format) with NUM_CH channels of SAMPLE_W-bit samples at a programmable SCK rate.
- Sample sets are started by an external strobe, with one-deep pending capture and overrun reporting.
- Sits between the audio/sample source and the board DAC pins (sck, sdi, ld).

Parameters:
- NUM_CH, 2, number of DAC channels, 1..15; channel c uses DAC address c.
- SAMPLE_W, 16, bits per sample, 1..16; left-justified into the 16-bit data field, low bits zero.
- CLK_DIV, 2, SCK half-period in clk cycles, ≥1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (asserted = 0).
- sample  in  NUM_CH*SAMPLE_W  channel c at [c*SAMPLE_W +: SAMPLE_W].
- strobe  in  1  request to transmit the current sample set.
- next  out  1  one-cycle pulse: sample set latched, source may change inputs.
- busy  out  1  high while any frame is in progress or a request is pending.
- overrun  out  1  one-cycle pulse: strobe lost because one request was already pending.
- sck  out  1  serial clock to DAC.
- sdi  out  1  serial data to DAC, MSB first.
- ld  out  1  DAC chip select / load, active low.

Behaviour:
- Reset values while reset=0 (asynchronous): sck=0, sdi=0, ld=1, next=0, busy=0, overrun=0. State is IDLE and pending is clear. Reset mid-frame aborts immediately; no partial update is guaranteed.
- Frame per channel, 32 bits: 8'h00, cmd 4'h3 (write and update n), addr 4-bit c, data 16 bits = sample left-justified.
- States:
  - IDLE
  - LATCH
  - SHIFT
  - GAP
- IDLE: strobe=1 at edge t → LATCH.
- LATCH (cycle t+1):
  - All NUM_CH samples are copied to an internal register.
  - next=1 for this cycle only.
  - ld falls, sdi = frame bit 31, channel index = 0.
  - Next state is SHIFT.
- SHIFT:
  - sck rises CLK_DIV cycles after ld falls, then toggles every CLK_DIV cycles.
  - sdi advances on each sck falling edge.
  - On the 32nd falling edge, ld rises in the same cycle, sdi=0 → GAP.
  - ld is low for exactly 64*CLK_DIV cycles.
- GAP:
  - ld high for CLK_DIV cycles.
  - If channels remain: ld falls for channel c+1, sdi = bit 31 of that frame → SHIFT.
  - Else: if pending is set, clear it → LATCH; otherwise → IDLE.
- Per-set timing:
  - Per-channel period is 65*CLK_DIV cycles.
  - A set lasts NUM_CH*65*CLK_DIV cycles from the LATCH cycle.
  - Back-to-back sets are seamless apart from the LATCH cycle.
- Strobe while not IDLE:
  - If pending=0, set pending.
  - If pending=1, pulse overrun and keep pending set.
  - Strobe in the LATCH cycle counts as not IDLE.
- busy = (state≠IDLE) | pending.
- NUM_CH=1: GAP always takes the last-channel branch.
- SAMPLE_W=16: no padding.

Optional Feature:
- DAC_SIGNED_IN_EN defined: samples are two's complement. The MSB of each sample is inverted at LATCH (offset binary), so 0 maps to mid-scale.
- Not defined: samples are passed unchanged as unsigned.

Decomposition:
- Package dac_pkg:
  - FRAME_W=32, LEAD_W=8, CMD_WR_UPD=4'h3
  - state enum {IDLE, LATCH, SHIFT, GAP}
  - frame-building function (cmd, addr, left-justified data)
- Sub-module dac_shift: one-frame serializer.
  - Inputs: load pulse, 32-bit word, CLK_DIV.
  - Outputs: sck, sdi, ld, done.
- dac_multi holds the channel sequencer, sample latch, pending/overrun logic and the optional signed conversion.

Test Plan:
- NUM_CH=2, CLK_DIV=2, sample={AA55,0FF0}, one strobe → next at t+1. Frame 32'h00300FF0, then 32'h0031AA55. Each ld-low is 128 cycles, gap 2 cycles, busy 261 cycles from strobe edge.
- Strobe during channel 0 of set 1 → pending; set 2 LATCH follows set 1's final GAP with no extra idle; no overrun.
- Three strobes during one set → exactly one pending set plus one overrun pulse on the third strobe.
- SAMPLE_W=12, NUM_CH=1, sample=12'hABC → data field 16'hABC0, frame 32'h0030ABC0.
- DAC_SIGNED_IN_EN, SAMPLE_W=16, sample 16'h0000 and 16'h8000 → data 16'h8000 and 16'h0000.
- Reset asserted mid-SHIFT of channel 1 → same cycle: ld=1, sck=0, busy=0. After release, the next strobe produces a complete channel 0 frame.
